// File: rtl/core_pkg.sv
// Shared definitions for the core's pipeline control blocks:
// the freeze-FSM state type and default widths.
package core_pkg;

  localparam int REG_W = 3;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones, with synchronous active-high clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  // NOTE: sequential state is written with <= only, so every always_ff reads
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard / stall controller: load-use bubbles, branch flushes,
// fetch and data-memory stalls, HALT freeze, plus two performance counters.
module hazard_ctrl #(
  parameter int CNT_W = core_pkg::CNT_W,
  parameter int REG_W = core_pkg::REG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_useRs,
  input  logic             ID_useRt,
  input  logic [REG_W-1:0] ID_EX_Rd,
  input  logic             ID_EX_memRead,
  input  logic             ID_EX_regWrite,
  input  logic             branch_taken_EX,
  input  logic             imem_stall,
  input  logic             dmem_req,
  input  logic             dmem_done,
  input  logic             halt_WB,
  output logic             pc_write,
  output logic             pc_sel_branch,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             EX_MEM_write,
  output logic             MEM_WB_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  import core_pkg::*;

  state_e state, state_next;
  logic   load_use;
  logic   mem_wait;
  logic   branch_fire;
  logic   stall_en;

  assign load_use = ID_EX_memRead && ID_EX_regWrite &&
                    ((ID_useRs && (ID_Rs == ID_EX_Rd)) ||
                     (ID_useRt && (ID_Rt == ID_EX_Rd)));
  assign mem_wait = dmem_req && !dmem_done;

  // NOTE: reset is synchronous; the state register only needs the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Priority mux: the first matching rule owns every output.
  // NOTE: every output gets a default first, so no path through the
  // if-chain can leave one unassigned and infer a latch.
  always_comb begin
    pc_write      = 1'b1;
    pc_sel_branch = 1'b0;
    IF_ID_write   = 1'b1;
    ID_EX_write   = 1'b1;
    EX_MEM_write  = 1'b1;
    MEM_WB_write  = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_flush   = 1'b0;
    halted        = 1'b0;
    branch_fire   = 1'b0;
    state_next    = state;

    if (rst) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
      MEM_WB_write = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      state_next   = RUN;
    end else if ((state == HALTED) || halt_WB) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
      MEM_WB_write = 1'b0;
      halted       = 1'b1;
      state_next   = HALTED;
    end else if (((state == MEM_WAIT) && !dmem_done) ||
                 ((state == RUN) && mem_wait)) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
      MEM_WB_write = 1'b0;
      state_next   = MEM_WAIT;
    end else begin
      // Pipeline moves this cycle; a finishing data access releases the freeze.
      state_next = RUN;
      if (branch_taken_EX) begin
        pc_sel_branch = 1'b1;
        IF_ID_flush   = 1'b1;
        ID_EX_flush   = 1'b1;
        branch_fire   = 1'b1;
      end else if (load_use || imem_stall) begin
        pc_write    = 1'b0;
        IF_ID_write = 1'b0;
        ID_EX_flush = 1'b1;
      end
    end
  end

  assign stall_en = !rst && !pc_write && (state != HALTED) && !halt_WB;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall_en),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (branch_fire),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver pushes model predictions per
// cycle, a negedge monitor pops and compares them with the DUT outputs.
module tb_hazard_ctrl;

  localparam int CNT_W = 10;
  localparam int REG_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             rst;
    logic [REG_W-1:0] rs, rt, rd;
    logic             use_rs, use_rt, mem_read, reg_write;
    logic             br, imem, req, done, halt;
  } stim_t;

  // ctl = {pc_write, pc_sel_branch, IF_ID_w, ID_EX_w, EX_MEM_w, MEM_WB_w,
  //        IF_ID_flush, ID_EX_flush, halted}
  typedef struct {
    logic [8:0] ctl;
    int         stall;
    int         flush;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [REG_W-1:0] ID_Rs, ID_Rt, ID_EX_Rd;
  logic ID_useRs, ID_useRt, ID_EX_memRead, ID_EX_regWrite;
  logic branch_taken_EX, imem_stall, dmem_req, dmem_done, halt_WB;
  logic pc_write, pc_sel_branch, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write;
  logic IF_ID_flush, ID_EX_flush, halted;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  hazard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_useRs(ID_useRs), .ID_useRt(ID_useRt),
    .ID_EX_Rd(ID_EX_Rd), .ID_EX_memRead(ID_EX_memRead), .ID_EX_regWrite(ID_EX_regWrite),
    .branch_taken_EX(branch_taken_EX), .imem_stall(imem_stall),
    .dmem_req(dmem_req), .dmem_done(dmem_done), .halt_WB(halt_WB),
    .pc_write(pc_write), .pc_sel_branch(pc_sel_branch),
    .IF_ID_write(IF_ID_write), .ID_EX_write(ID_EX_write),
    .EX_MEM_write(EX_MEM_write), .MEM_WB_write(MEM_WB_write),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .halted(halted),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: "is the core waiting on data memory", "is it halted",
  // and the two event tallies as plain integers.
  bit m_waiting = 0;
  bit m_halted  = 0;
  int m_stall   = 0;
  int m_flush   = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle's inputs, predict the outputs, queue the prediction.
  task automatic step(input stim_t s, input string tag);
    exp_t e;
    bit   lu, pcw, brf;
    @(posedge clk);
    #1;
    rst = s.rst; ID_Rs = s.rs; ID_Rt = s.rt; ID_EX_Rd = s.rd;
    ID_useRs = s.use_rs; ID_useRt = s.use_rt;
    ID_EX_memRead = s.mem_read; ID_EX_regWrite = s.reg_write;
    branch_taken_EX = s.br; imem_stall = s.imem;
    dmem_req = s.req; dmem_done = s.done; halt_WB = s.halt;

    e.tag = tag;
    e.stall = m_stall;
    e.flush = m_flush;
    brf = 0;
    lu = s.mem_read && s.reg_write &&
         ((s.use_rs && s.rs == s.rd) || (s.use_rt && s.rt == s.rd));
    if (s.rst) begin
      e.ctl = 9'b0_0_0000_11_0;
    end else if (m_halted || s.halt) begin
      e.ctl = 9'b0_0_0000_00_1;
    end else if (m_waiting ? !s.done : (s.req && !s.done)) begin
      e.ctl = 9'b0_0_0000_00_0;
    end else if (s.br) begin
      e.ctl = 9'b1_1_1111_11_0;
      brf = 1;
    end else if (lu || s.imem) begin
      e.ctl = 9'b0_0_0111_01_0;
    end else begin
      e.ctl = 9'b1_0_1111_00_0;
    end
    exp_q.push_back(e);

    // Advance the model to the next cycle.
    pcw = e.ctl[8];
    if (s.rst) begin
      m_waiting = 0; m_halted = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!pcw && !m_halted && !s.halt && m_stall < CMAX) m_stall++;
      if (brf && m_flush < CMAX) m_flush++;
      if (m_halted || s.halt) m_halted = 1;
      else m_waiting = (m_waiting ? !s.done : (s.req && !s.done));
    end
  endtask

  // Monitor: outputs are valid every cycle; compare away from the rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.tag, ".ctl"}, int'({pc_write, pc_sel_branch, IF_ID_write, ID_EX_write,
                                  EX_MEM_write, MEM_WB_write, IF_ID_flush,
                                  ID_EX_flush, halted}), int'(e.ctl));
      check({e.tag, ".stall_cycles"}, int'(stall_cycles), e.stall);
      check({e.tag, ".flush_count"}, int'(flush_count), e.flush);
    end
  end

  initial begin
    stim_t s;
    rst = 1'b1; ID_Rs = '0; ID_Rt = '0; ID_EX_Rd = '0;
    ID_useRs = 0; ID_useRt = 0; ID_EX_memRead = 0; ID_EX_regWrite = 0;
    branch_taken_EX = 0; imem_stall = 0; dmem_req = 0; dmem_done = 0; halt_WB = 0;
    @(posedge clk);

    s = idle(); s.rst = 1;
    step(s, "reset"); step(s, "reset");
    step(idle(), "idle");

    // Load-use on Rs: one bubble, then normal advance.
    s = idle(); s.mem_read = 1; s.reg_write = 1; s.rd = 3; s.rs = 3; s.use_rs = 1;
    step(s, "load_use_rs");
    step(idle(), "after_load_use");
    s.use_rs = 0;
    step(s, "no_use_rs");
    s = idle(); s.mem_read = 1; s.reg_write = 1; s.rd = 5; s.rt = 5; s.use_rt = 1;
    step(s, "load_use_rt");

    // Branch beats load-use and fetch stall.
    s = idle(); s.mem_read = 1; s.reg_write = 1; s.rd = 2; s.rs = 2; s.use_rs = 1;
    s.imem = 1; s.br = 1;
    step(s, "branch_prio");
    step(idle(), "idle");

    // Data access done 3 cycles after request, then a same-cycle done.
    s = idle(); s.req = 1;
    for (int i = 0; i < 3; i++) step(s, "dmem_freeze");
    s.done = 1;
    step(s, "dmem_done");
    step(s, "dmem_same_cycle");
    s = idle(); s.req = 1; s.br = 1;
    step(s, "branch_in_freeze");
    s.done = 1;
    step(s, "branch_after_freeze");

    // HALT while waiting on memory; stays halted until reset.
    s = idle(); s.req = 1;
    step(s, "pre_halt_wait");
    s.halt = 1;
    step(s, "halt_in_wait");
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.br = 1; s.imem = 1; s.done = 1;
      step(s, "halted_hold");
    end
    s = idle(); s.rst = 1;
    step(s, "reset_from_halt");
    step(idle(), "idle_after_halt");

    // Saturation of stall_cycles.
    s = idle(); s.imem = 1;
    for (int i = 0; i < CMAX + 6; i++) step(s, "saturate");
    s = idle(); s.rst = 1;
    step(s, "reset_sat");

    // Reset in the middle of a freeze.
    s = idle(); s.req = 1;
    step(s, "freeze_a"); step(s, "freeze_b");
    s.rst = 1;
    step(s, "reset_mid_freeze");
    step(idle(), "run_after_reset");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      s.rst       = ($urandom_range(199) == 0);
      s.halt      = ($urandom_range(299) == 0);
      s.rs        = REG_W'($urandom);
      s.rt        = REG_W'($urandom);
      s.rd        = REG_W'($urandom);
      s.use_rs    = $urandom_range(1);
      s.use_rt    = $urandom_range(1);
      s.mem_read  = $urandom_range(1);
      s.reg_write = $urandom_range(1);
      s.br        = ($urandom_range(5) == 0);
      s.imem      = ($urandom_range(3) == 0);
      s.req       = ($urandom_range(2) == 0);
      s.done      = $urandom_range(1);
      if (m_halted && $urandom_range(7) == 0) s.rst = 1;
      step(s, "random");
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
